// File: rtl/vga_pingpong_buffer.sv
// rtl/vga_pingpong_buffer.sv - double-buffered per-column sprite store for the VGA renderer
// Writer fills the back bank; banks swap at frame_end only once the back frame is declared complete.

module vga_pingpong_buffer #(
   parameter int                DATA_W         = 8,
   parameter int                DEPTH          = 160,
   parameter int                ADDR_W         = 8,
   parameter int                CHANNELS       = 2,
   parameter int                CH_W           = 1,
   parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
   parameter bit                REPEAT_ON_MISS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_done,
   input  logic              clr_start,
   input  logic              frame_end,
   input  logic              rd_en,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              back_ready,
   output logic              clr_busy,
   output logic              front_sel,
   output logic [15:0]       miss_cnt,
   output logic              err
);

   localparam int WORDS = CHANNELS * DEPTH;
   localparam int IDX_W = $clog2(2 * WORDS);
   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_READY} state_t;

   state_t            state_q, state_d;
   logic              front_sel_q, front_sel_d;
   logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic [15:0]       miss_cnt_q, miss_cnt_d;
   logic              err_q, err_d;
   logic              blank_q, blank_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic [DATA_W-1:0] mem_q [2*WORDS];
   logic              mem_we;
   logic [IDX_W-1:0]  mem_widx;
   logic [DATA_W-1:0] mem_wdata;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic              back_sel;
   logic              wr_in_range, rd_in_range;
   logic              swap, miss;

   always_comb begin
      state_d     = state_q;
      front_sel_d = front_sel_q;
      clr_cnt_d   = clr_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_d       = err_q;
      blank_d     = blank_q;
      rd_valid_d  = rd_en;
      rd_data_d   = '0;
      mem_we      = 1'b0;
      mem_widx    = '0;
      mem_wdata   = wr_data;
      swap        = 1'b0;
      miss        = 1'b0;

      back_sel    = ~front_sel_q;
      wr_in_range = (32'(wr_ch) < CHANNELS) && (32'(wr_addr) < DEPTH);
      rd_in_range = (32'(rd_ch) < CHANNELS) && (32'(rd_addr) < DEPTH);
      wr_idx      = IDX_W'(32'(back_sel) * WORDS + 32'(wr_ch) * DEPTH + 32'(wr_addr));
      rd_idx      = IDX_W'(32'(front_sel_q) * WORDS + 32'(rd_ch) * DEPTH + 32'(rd_addr));

      // Reads always see the pre-edge front bank, so a read in the swap cycle gets old data.
      if (rd_en && rd_in_range) begin
         rd_data_d = blank_q ? CLEAR_VAL : mem_q[rd_idx];
      end

      case (state_q)
         S_IDLE: begin
            if (wr_en && wr_in_range) begin
               mem_we   = 1'b1;
               mem_widx = wr_idx;
            end
            if (wr_done) begin
               if (clr_start) err_d = 1'b1;
               if (frame_end) swap = 1'b1;
               else           state_d = S_READY;
            end else if (clr_start) begin
               state_d   = S_CLEAR;
               clr_cnt_d = '0;
            end
         end
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_widx  = IDX_W'(32'(back_sel) * WORDS + 32'(clr_cnt_q));
            mem_wdata = CLEAR_VAL;
            if (32'(clr_cnt_q) == WORDS - 1) begin
               state_d   = S_IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + CNT_W'(1);
            end
            if (wr_en || wr_done || clr_start) err_d = 1'b1;
         end
         S_READY: begin
            if (frame_end) swap = 1'b1;
            if (wr_en || wr_done || clr_start) err_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      miss = frame_end && !swap;

      if (swap) begin
         front_sel_d = ~front_sel_q;
         state_d     = S_IDLE;
         blank_d     = 1'b0;
      end
      if (miss) begin
         if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
         if (!REPEAT_ON_MISS) blank_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         front_sel_q <= 1'b0;
         clr_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         err_q       <= 1'b0;
         blank_q     <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_d;
         clr_cnt_q   <= clr_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_q       <= err_d;
         blank_q     <= blank_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   // Storage is never reset; a reset edge also suppresses the pending write so a sweep stops dead.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[mem_widx] <= mem_wdata;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign back_ready = (state_q == S_READY);
   assign clr_busy   = (state_q == S_CLEAR);
   assign front_sel  = front_sel_q;
   assign miss_cnt   = miss_cnt_q;
   assign err        = err_q;

endmodule

// File: tb/tb_vga_pingpong_buffer.sv
// tb/tb_vga_pingpong_buffer.sv - bench for vga_pingpong_buffer
// Two instances: repeat-on-miss with CLEAR_VAL 0, and blank-on-miss with CLEAR_VAL 0x5A.

module tb_vga_pingpong_buffer;

   localparam int DEPTH = 160;
   localparam int CH    = 2;
   localparam int WORDS = CH * DEPTH;
   localparam logic [7:0] CV_A = 8'h00;
   localparam logic [7:0] CV_B = 8'h5A;

   logic       clk = 1'b0;
   logic       reset, wr_en, wr_done, clr_start, frame_end, rd_en;
   logic [0:0] wr_ch, rd_ch;
   logic [7:0] wr_addr, wr_data, rd_addr;

   logic [7:0]  rd_data_a, rd_data_b;
   logic        rd_valid_a, rd_valid_b, back_ready_a, back_ready_b;
   logic        clr_busy_a, clr_busy_b, front_sel_a, front_sel_b, err_a, err_b;
   logic [15:0] miss_cnt_a, miss_cnt_b;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   vga_pingpong_buffer #(.CLEAR_VAL(CV_A), .REPEAT_ON_MISS(1'b1)) dut_a (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_done(wr_done), .clr_start(clr_start), .frame_end(frame_end),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .back_ready(back_ready_a), .clr_busy(clr_busy_a),
      .front_sel(front_sel_a), .miss_cnt(miss_cnt_a), .err(err_a)
   );

   vga_pingpong_buffer #(.CLEAR_VAL(CV_B), .REPEAT_ON_MISS(1'b0)) dut_b (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_done(wr_done), .clr_start(clr_start), .frame_end(frame_end),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .back_ready(back_ready_b), .clr_busy(clr_busy_b),
      .front_sel(front_sel_b), .miss_cnt(miss_cnt_b), .err(err_b)
   );

   // Reference: bank contents as arrays plus a few flags/counters describing the frame protocol.
   logic [7:0] ma [2][WORDS];
   logic [7:0] mb [2][WORDS];
   bit         kn [2][WORDS];
   bit         m_front, m_ready, m_blank, m_err;
   int         m_clr_left, m_miss;
   bit         e_rv, e_kn_a, e_kn_b;
   logic [7:0] e_rd_a, e_rd_b;

   always @(posedge clk) begin : model_p
      bit was_ready, was_clr, idle, back, do_swap;
      int idx, w;
      if (reset) begin
         m_front = 0; m_ready = 0; m_blank = 0; m_err = 0;
         m_clr_left = 0; m_miss = 0;
         e_rv = 0; e_rd_a = 8'h00; e_rd_b = 8'h00; e_kn_a = 1; e_kn_b = 1;
      end else begin
         e_rv = rd_en;
         if (rd_en) begin
            if (int'(rd_ch) >= CH || int'(rd_addr) >= DEPTH) begin
               e_rd_a = 8'h00; e_rd_b = 8'h00; e_kn_a = 1; e_kn_b = 1;
            end else begin
               idx    = int'(rd_ch) * DEPTH + int'(rd_addr);
               e_rd_a = ma[m_front][idx];
               e_kn_a = kn[m_front][idx];
               e_rd_b = m_blank ? CV_B : mb[m_front][idx];
               e_kn_b = m_blank ? 1'b1 : kn[m_front][idx];
            end
         end
         was_ready = m_ready;
         was_clr   = (m_clr_left > 0);
         idle      = !was_ready && !was_clr;
         back      = !m_front;
         if (wr_en) begin
            if (!idle) m_err = 1;
            else if (int'(wr_ch) < CH && int'(wr_addr) < DEPTH) begin
               idx = int'(wr_ch) * DEPTH + int'(wr_addr);
               ma[back][idx] = wr_data;
               mb[back][idx] = wr_data;
               kn[back][idx] = 1;
            end
         end
         if (was_clr) begin
            w = WORDS - m_clr_left;
            ma[back][w] = CV_A;
            mb[back][w] = CV_B;
            kn[back][w] = 1;
            m_clr_left--;
         end
         if ((wr_done || clr_start) && !idle) m_err = 1;
         if (idle && wr_done && clr_start) m_err = 1;
         do_swap = frame_end && (was_ready || (idle && wr_done));
         if (idle && wr_done && !frame_end) m_ready = 1;
         if (idle && !wr_done && clr_start) m_clr_left = WORDS;
         if (do_swap) begin
            m_front = !m_front; m_ready = 0; m_blank = 0;
         end else if (frame_end) begin
            if (m_miss < 65535) m_miss++;
            m_blank = 1;
         end
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("front_sel_a", 32'(front_sel_a), 32'(m_front));
         cmp("front_sel_b", 32'(front_sel_b), 32'(m_front));
         cmp("back_ready_a", 32'(back_ready_a), 32'(m_ready));
         cmp("back_ready_b", 32'(back_ready_b), 32'(m_ready));
         cmp("clr_busy_a", 32'(clr_busy_a), 32'(m_clr_left > 0));
         cmp("clr_busy_b", 32'(clr_busy_b), 32'(m_clr_left > 0));
         cmp("miss_cnt_a", 32'(miss_cnt_a), 32'(m_miss));
         cmp("miss_cnt_b", 32'(miss_cnt_b), 32'(m_miss));
         cmp("err_a", 32'(err_a), 32'(m_err));
         cmp("err_b", 32'(err_b), 32'(m_err));
         cmp("rd_valid_a", 32'(rd_valid_a), 32'(e_rv));
         cmp("rd_valid_b", 32'(rd_valid_b), 32'(e_rv));
         if (e_rv && e_kn_a) cmp("rd_data_a", 32'(rd_data_a), 32'(e_rd_a));
         if (e_rv && e_kn_b) cmp("rd_data_b", 32'(rd_data_b), 32'(e_rd_b));
      end
   end

   task automatic clr_in();
      wr_en = 0; wr_ch = 0; wr_addr = 0; wr_data = 0; wr_done = 0;
      clr_start = 0; frame_end = 0; rd_en = 0; rd_ch = 0; rd_addr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      clr_in();
   endtask

   task automatic wr(input int ch, input int addr, input logic [7:0] d);
      wr_en = 1; wr_ch = 1'(ch); wr_addr = 8'(addr); wr_data = d;
      step();
   endtask

   task automatic rd(input string nm, input int ch, input int addr,
                     input logic [7:0] ea, input logic [7:0] eb);
      rd_en = 1; rd_ch = 1'(ch); rd_addr = 8'(addr);
      step();
      cmp({nm, "_a"}, 32'(rd_data_a), 32'(ea));
      cmp({nm, "_b"}, 32'(rd_data_b), 32'(eb));
      cmp({nm, "_valid"}, 32'(rd_valid_a), 32'd1);
   endtask

   task automatic chk_reset(input string nm);
      cmp({nm, "_front"}, 32'(front_sel_a), 32'd0);
      cmp({nm, "_ready"}, 32'(back_ready_a), 32'd0);
      cmp({nm, "_busy"}, 32'(clr_busy_a), 32'd0);
      cmp({nm, "_rdata"}, 32'(rd_data_b), 32'd0);
      cmp({nm, "_rvalid"}, 32'(rd_valid_a), 32'd0);
      cmp({nm, "_miss"}, 32'(miss_cnt_b), 32'd0);
      cmp({nm, "_err"}, 32'(err_a), 32'd0);
   endtask

   task automatic run_clear(input bit overlap, output int busy);
      clr_start = 1;
      step();
      busy = clr_busy_a ? 1 : 0;
      if (overlap) begin
         wr_en = 1; wr_ch = 1; wr_addr = 8'd7; wr_data = 8'hEE;
         step();
         if (clr_busy_a) busy++;
      end
      while (clr_busy_a && busy < 1000) begin
         step();
         if (clr_busy_a) busy++;
      end
   endtask

   initial begin
      int busy;
      clr_in();
      reset  = 1;
      chk_en = 1;
      step();
      reset = 0;
      chk_reset("reset0");

      wr(0, 5, 8'h3C);
      wr_done = 1; step();
      cmp("basic_ready", 32'(back_ready_a), 32'd1);
      frame_end = 1; step();
      cmp("basic_front", 32'(front_sel_a), 32'd1);
      cmp("basic_ready_low", 32'(back_ready_a), 32'd0);
      rd("basic_rd", 0, 5, 8'h3C, 8'h3C);

      frame_end = 1; step();
      frame_end = 1; step();
      cmp("miss_cnt2", 32'(miss_cnt_a), 32'd2);
      cmp("miss_front", 32'(front_sel_b), 32'd1);
      rd("miss_rd", 0, 5, 8'h3C, CV_B);

      run_clear(1'b1, busy);
      cmp("clear_cycles", 32'(busy), 32'd320);
      cmp("clear_overlap_err", 32'(err_a), 32'd1);
      wr_done = 1; step();
      frame_end = 1; step();
      cmp("clear_swap_front", 32'(front_sel_a), 32'd0);
      rd("clear_rd_ovl", 1, 7, CV_A, CV_B);
      rd("clear_rd_first", 0, 0, CV_A, CV_B);
      rd("clear_rd_last", 1, 159, CV_A, CV_B);
      run_clear(1'b0, busy);
      cmp("clear2_cycles", 32'(busy), 32'd320);

      clr_start = 1; step();
      repeat (10) step();
      reset = 1; step();
      reset = 0;
      chk_reset("reset_midclear");

      wr_en = 1; wr_ch = 1; wr_addr = 8'd100; wr_data = 8'h77;
      wr_done = 1; frame_end = 1;
      step();
      cmp("simul_front", 32'(front_sel_a), 32'd1);
      cmp("simul_miss", 32'(miss_cnt_a), 32'd0);
      rd("simul_rd", 1, 100, 8'h77, 8'h77);

      wr(0, DEPTH, 8'h11);
      cmp("oob_write_err", 32'(err_a), 32'd0);
      wr_done = 1; step();
      wr(0, 3, 8'h22);
      cmp("ready_write_err", 32'(err_b), 32'd1);
      frame_end = 1; step();
      rd("ready_write_nochg", 0, 3, CV_A, CV_B);
      rd("oob_rd", 0, 200, 8'h00, 8'h00);

      wr_done = 1; step();
      cmp("pre_reset_ready", 32'(back_ready_a), 32'd1);
      reset = 1; step();
      reset = 0;
      chk_reset("reset_ready");

      for (int i = 0; i < 6000; i++) begin
         reset     = ($urandom_range(0, 799) == 0);
         wr_en     = ($urandom_range(0, 1) == 0);
         wr_ch     = 1'($urandom_range(0, 1));
         wr_addr   = 8'($urandom_range(0, 170));
         wr_data   = 8'($urandom);
         wr_done   = ($urandom_range(0, 29) == 0);
         clr_start = ($urandom_range(0, 249) == 0);
         frame_end = ($urandom_range(0, 39) == 0);
         rd_en     = ($urandom_range(0, 1) == 0);
         rd_ch     = 1'($urandom_range(0, 1));
         rd_addr   = 8'($urandom_range(0, 175));
         step();
         reset = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
